// File: rtl/csoc_uart_tx_bridge.sv
// -----------------------------------------------------------------------------
// csoc_uart_tx_bridge
//
// Return path from the CSoC to the host. The CSoC serial output (8N1, idle
// high) is synchronised, deserialised into bytes, buffered in a byte FIFO and
// handed to the host UART transmitter through the tx_data / new_tx_data /
// tx_busy handshake. cmd_parser owns the opposite (host -> CSoC) direction.
//
// Optional feature (macro CSOC_TX_HEX_EN):
//   defined   : every byte is sent as three ASCII chars - upper-case hex of the
//               high nibble, hex of the low nibble, then a space (8'h20). Each
//               char uses its own SEND/HOLD handshake; the FIFO pops once per
//               byte.
//   undefined : raw byte pass-through, one handshake per byte.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 4)
//   FIFO_DEPTH   : byte FIFO depth (power of 2, >= 2)
//
// Ports
//   clk             in   system clock
//   rstn            in   synchronous, active-low reset
//   csoc_uart_write in   asynchronous serial line from the CSoC, idle high
//   tx_data         out  byte/char offered to the host transmitter
//   new_tx_data     out  one-cycle strobe: tx_data valid, start transmission
//   tx_busy         in   host transmitter busy
//   frame_err       out  one-cycle pulse: stop bit sampled low, byte discarded
//   overflow        out  sticky: a byte was dropped because the FIFO was full
//   fifo_count      out  bytes currently buffered (0..FIFO_DEPTH)
//
// Timing: the edge that samples a good stop bit registers a push request, the
// FIFO is written on the next edge, the TX FSM pops into tx_data on the edge
// after that (SEND), and new_tx_data is the registered image of SEND, so the
// strobe rises three edges after the stop-bit sample with tx_data already
// stable for one cycle.
// -----------------------------------------------------------------------------
module csoc_uart_tx_bridge #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          csoc_uart_write,
   output logic [7:0]                    tx_data,
   output logic                          new_tx_data,
   input  logic                          tx_busy,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int HALF_I = CLKS_PER_BIT / 2 - 1;
   localparam int LAST_I = CLKS_PER_BIT - 1;

   localparam logic [CNT_W-1:0] HALF_LAST = HALF_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] BIT_LAST  = LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   FILL_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   FILL_FULL = FIFO_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_HOLD} tx_state_t;

`ifdef CSOC_TX_HEX_EN
   // Upper-case ASCII hex digit for one nibble.
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10) begin
         c = 8'h30 + {4'h0, nib};
      end else begin
         c = 8'h37 + {4'h0, nib};
      end
      return c;
   endfunction
`endif

   // ---------------------------------------------------------------- sync
   logic sync1_r, sync2_r;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= csoc_uart_write;
         sync2_r <= sync1_r;
      end
   end

   // ------------------------------------------------------------------ RX
   rx_state_t        rx_state_r, rx_state_s;
   logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
   logic [2:0]       rx_bit_r, rx_bit_s;
   logic [7:0]       rx_shift_r, rx_shift_s;
   logic             rx_push_s, rx_ferr_s;
   logic             rx_push_r, frame_err_r;

   // RX state, bit timer, bit index, shift register and result strobes.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_state_r  <= RX_IDLE;
         rx_cnt_r    <= CNT_ZERO;
         rx_bit_r    <= 3'd0;
         rx_shift_r  <= 8'h00;
         rx_push_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rx_state_r  <= rx_state_s;
         rx_cnt_r    <= rx_cnt_s;
         rx_bit_r    <= rx_bit_s;
         rx_shift_r  <= rx_shift_s;
         rx_push_r   <= rx_push_s;
         frame_err_r <= rx_ferr_s;
      end
   end

   // RX next state: half-bit start check, then samples in the middle of each bit.
   always_comb begin
      rx_state_s = rx_state_r;
      rx_cnt_s   = rx_cnt_r;
      rx_bit_s   = rx_bit_r;
      rx_shift_s = rx_shift_r;
      rx_push_s  = 1'b0;
      rx_ferr_s  = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            rx_cnt_s = CNT_ZERO;
            if (!sync2_r) begin
               rx_state_s = RX_START;
            end else begin
               rx_state_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_r == HALF_LAST) begin
               rx_cnt_s = CNT_ZERO;
               rx_bit_s = 3'd0;
               // A start bit that is gone by mid-bit was a glitch.
               if (!sync2_r) begin
                  rx_state_s = RX_DATA;
               end else begin
                  rx_state_s = RX_IDLE;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == BIT_LAST) begin
               rx_cnt_s   = CNT_ZERO;
               rx_shift_s = {sync2_r, rx_shift_r[7:1]};   // LSB first
               if (rx_bit_r == 3'd7) begin
                  rx_state_s = RX_STOP;
               end else begin
                  rx_bit_s = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt_r == BIT_LAST) begin
               rx_cnt_s   = CNT_ZERO;
               rx_state_s = RX_IDLE;
               if (sync2_r) begin
                  rx_push_s = 1'b1;
               end else begin
                  rx_ferr_s = 1'b1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         default: begin
            rx_state_s = RX_IDLE;
            rx_cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // ---------------------------------------------------------------- FIFO
   // rx_shift_r is stable for a full bit time after the stop sample, so the
   // registered push can take the byte straight from the shift register.
   logic [7:0]       fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [PTR_W:0]   fill_r;
   logic             fifo_full_s, fifo_empty_s, push_ok_s, pop_s, drop_s;
   logic [7:0]       fifo_head_s;

   // Full/empty use the count at the start of the cycle, so a push while
   // full is dropped even if the TX side pops in the same cycle.
   always_comb begin
      fifo_full_s  = (fill_r == FILL_FULL);
      fifo_empty_s = (fill_r == {(PTR_W+1){1'b0}});
      push_ok_s    = rx_push_r & ~fifo_full_s;
      drop_s       = rx_push_r & fifo_full_s;
      fifo_head_s  = fifo_mem_r[rd_ptr_r];
   end

   // FIFO storage; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem_r[wr_ptr_r] <= rx_shift_r;
      end
   end

   // FIFO pointers, fill level and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         fill_r     <= {(PTR_W+1){1'b0}};
         overflow   <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_s})
            2'b10:   fill_r <= fill_r + FILL_ONE;
            2'b01:   fill_r <= fill_r - FILL_ONE;
            default: fill_r <= fill_r;
         endcase
         if (drop_s) begin
            overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------ TX
   tx_state_t  tx_state_r, tx_state_s;
   logic       guard_r, guard_s;
   logic [7:0] tx_data_r, tx_data_s;
   logic       new_tx_data_r;
`ifdef CSOC_TX_HEX_EN
   logic [1:0] nib_r, nib_s;
   logic [7:0] hex_byte_r, hex_byte_s;
`endif

   // TX state, data register and the strobe that follows the SEND state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_state_r    <= TX_IDLE;
         guard_r       <= 1'b0;
         tx_data_r     <= 8'h00;
         new_tx_data_r <= 1'b0;
`ifdef CSOC_TX_HEX_EN
         nib_r         <= 2'd0;
         hex_byte_r    <= 8'h00;
`endif
      end else begin
         tx_state_r    <= tx_state_s;
         guard_r       <= guard_s;
         tx_data_r     <= tx_data_s;
         new_tx_data_r <= (tx_state_r == TX_SEND);
`ifdef CSOC_TX_HEX_EN
         nib_r         <= nib_s;
         hex_byte_r    <= hex_byte_s;
`endif
      end
   end

   // TX next state: pop into tx_data, strobe once, then a guard cycle so the
   // transmitter can raise tx_busy before it is trusted to mean "done".
   always_comb begin
      tx_state_s = tx_state_r;
      guard_s    = guard_r;
      tx_data_s  = tx_data_r;
      pop_s      = 1'b0;
`ifdef CSOC_TX_HEX_EN
      nib_s      = nib_r;
      hex_byte_s = hex_byte_r;
`endif
      case (tx_state_r)
         TX_IDLE: begin
            if (!fifo_empty_s && !tx_busy) begin
               pop_s      = 1'b1;
               tx_state_s = TX_SEND;
`ifdef CSOC_TX_HEX_EN
               hex_byte_s = fifo_head_s;
               nib_s      = 2'd0;
               tx_data_s  = hex_char(fifo_head_s[7:4]);
`else
               tx_data_s  = fifo_head_s;
`endif
            end else begin
               tx_state_s = TX_IDLE;
            end
         end
         TX_SEND: begin
            tx_state_s = TX_HOLD;
            guard_s    = 1'b1;
         end
         TX_HOLD: begin
            if (guard_r) begin
               guard_s = 1'b0;
            end else if (!tx_busy) begin
`ifdef CSOC_TX_HEX_EN
               // Walk high nibble -> low nibble -> space, one handshake each.
               if (nib_r == 2'd2) begin
                  tx_state_s = TX_IDLE;
               end else begin
                  nib_s      = nib_r + 2'd1;
                  tx_state_s = TX_SEND;
                  if (nib_r == 2'd0) begin
                     tx_data_s = hex_char(hex_byte_r[3:0]);
                  end else begin
                     tx_data_s = 8'h20;
                  end
               end
`else
               tx_state_s = TX_IDLE;
`endif
            end else begin
               tx_state_s = TX_HOLD;
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
            guard_s    = 1'b0;
         end
      endcase
   end

   assign tx_data     = tx_data_r;
   assign new_tx_data = new_tx_data_r;
   assign frame_err   = frame_err_r;
   assign fifo_count  = fill_r;

endmodule

// File: tb/tb_csoc_uart_tx_bridge.sv
// Self-checking bench for csoc_uart_tx_bridge (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// A transmitter model raises tx_busy for 20 clk after each strobe; busy_hold
// lets a test keep the transmitter busy. Build with +define+CSOC_TX_HEX_EN to
// expect the three-char hex rendering of every byte.
module tb_csoc_uart_tx_bridge;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   localparam logic [7:0] HEX_TBL [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                           8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

   logic       clk = 1'b0;
   logic       rstn;
   logic       csoc_uart_write;
   logic [7:0] tx_data;
   logic       new_tx_data;
   logic       tx_busy;
   logic       frame_err;
   logic       overflow;
   logic [2:0] fifo_count;

   csoc_uart_tx_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .csoc_uart_write (csoc_uart_write),
      .tx_data         (tx_data),
      .new_tx_data     (new_tx_data),
      .tx_busy         (tx_busy),
      .frame_err       (frame_err),
      .overflow        (overflow),
      .fifo_count      (fifo_count)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         chk_idx = 0;
   int         ferr_cnt = 0;
   int         width_err_cnt = 0;
   int         busy_err_cnt = 0;
   int         model_cnt = 0;
   logic       busy_hold = 1'b0;
   logic       strobe_prev = 1'b0;
   logic       ferr_prev = 1'b0;
   logic [7:0] last_char = 8'h00;
   logic [7:0] got_q [$];
   int         cyc_q [$];
   logic [7:0] exp_q [$];

   assign tx_busy = busy_hold | (model_cnt != 0);

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor + transmitter model, sampled on the falling edge.
   always @(negedge clk) begin
      if (new_tx_data === 1'b1) begin
         got_q.push_back(tx_data);
         cyc_q.push_back(cyc);
         if (strobe_prev === 1'b1) width_err_cnt++;
         if (tx_busy === 1'b1) busy_err_cnt++;
         model_cnt = 20;
      end else if (model_cnt != 0) begin
         model_cnt--;
      end
      if (frame_err === 1'b1) begin
         ferr_cnt++;
         if (ferr_prev === 1'b1) width_err_cnt++;
      end
      strobe_prev = new_tx_data;
      ferr_prev   = frame_err;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ferr;
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_byte(input logic [7:0] b);
`ifdef CSOC_TX_HEX_EN
      exp_q.push_back(HEX_TBL[b[7:4]]);
      exp_q.push_back(HEX_TBL[b[3:0]]);
      exp_q.push_back(8'h20);
      last_char = 8'h20;
`else
      exp_q.push_back(b);
      last_char = b;
`endif
   endtask

   task automatic check_chars(input string name);
      int n_got;
      n_got = got_q.size() - chk_idx;
      check({name, "_count"}, n_got, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n_got) check({name, "_char"}, {24'h0, got_q[chk_idx + i]}, {24'h0, exp_q[i]});
      end
      chk_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic drive_bit(input logic b);
      csoc_uart_write = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      csoc_uart_write = 1'b1;
   endtask

   task automatic wait_chars(input int budget);
      int n;
      n = 0;
      while ((got_q.size() < chk_idx + exp_q.size()) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check("wait_chars_timeout", (n < budget) ? 32'd1 : 32'd0, 32'd1);
      repeat (30) @(negedge clk);
   endtask

   initial begin
      int ferr_base;
      vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h5A, stop: 1'b0, exp_ferr: 1'b1};
      vecs[2] = '{data: 8'h3A, stop: 1'b1, exp_ferr: 1'b0};
      vecs[3] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 1'b0};

      // Reset state.
      rstn = 1'b0;
      csoc_uart_write = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_data", {24'h0, tx_data}, 32'h00);
      check("rst_new_tx_data", {31'h0, new_tx_data}, 32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      check("rst_overflow", {31'h0, overflow}, 32'h0);
      check("rst_fifo_count", {29'h0, fifo_count}, 32'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (10) @(negedge clk);

      // Table: single frames, good and bad stop bits.
      for (int v = 0; v < 5; v++) begin
         ferr_base = ferr_cnt;
         send_frame(vecs[v].data, vecs[v].stop);
         repeat (120) @(negedge clk);
         if (v == 0) check("latency", (cyc_q.size() > chk_idx) ? cyc_q[chk_idx] - start_cyc : -1, 32'd82);
         if (!vecs[v].exp_ferr) expect_byte(vecs[v].data);
         check_chars("vec");
         check("vec_frame_err", ferr_cnt - ferr_base, {31'h0, vecs[v].exp_ferr});
         check("vec_fifo_count", {29'h0, fifo_count}, 32'h0);
         check("vec_overflow", {31'h0, overflow}, 32'h0);
         check("vec_tx_data_hold", {24'h0, tx_data}, {24'h0, last_char});
      end

      // Transmitter busy: FIFO fills to DEPTH, extra bytes dropped.
      busy_hold = 1'b1;
      for (int b = 1; b <= 6; b++) send_frame(b[7:0], 1'b1);
      repeat (10) @(negedge clk);
      check("full_fifo_count", {29'h0, fifo_count}, DEPTH);
      check("full_overflow", {31'h0, overflow}, 32'h1);
      check("full_no_strobe", got_q.size() - chk_idx, 32'd0);
      busy_hold = 1'b0;
      for (int b = 1; b <= 4; b++) expect_byte(b[7:0]);
      wait_chars(1000);
      check_chars("drain");
      check("drain_fifo_count", {29'h0, fifo_count}, 32'h0);
      check("drain_overflow_sticky", {31'h0, overflow}, 32'h1);

      // Two-clock glitch on the line: ignored.
      ferr_base = ferr_cnt;
      @(posedge clk);
      #1 csoc_uart_write = 1'b0;
      repeat (2) @(posedge clk);
      #1 csoc_uart_write = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_frame_err", ferr_cnt - ferr_base, 32'd0);
      check("glitch_fifo_count", {29'h0, fifo_count}, 32'h0);
      check_chars("glitch");

      // Reset in the middle of data bit 4 of 8'hFF.
      @(posedge clk);
      #1;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      csoc_uart_write = 1'b1;
      repeat (CPB / 2) @(posedge clk);
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_tx_data", {24'h0, tx_data}, 32'h00);
      check("midrst_new_tx_data", {31'h0, new_tx_data}, 32'h0);
      check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
      check("midrst_overflow", {31'h0, overflow}, 32'h0);
      check("midrst_fifo_count", {29'h0, fifo_count}, 32'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (100) @(negedge clk);
      check_chars("midrst_no_byte");
      send_frame(8'h11, 1'b1);
      expect_byte(8'h11);
      wait_chars(300);
      check_chars("after_rst");
      check("after_rst_overflow", {31'h0, overflow}, 32'h0);

      check("strobe_width_errors", width_err_cnt, 32'd0);
      check("strobe_while_busy", busy_err_cnt, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
